// File: rtl/sha3_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha3_pkg : shared constants, types and helpers for the SHA3 core    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package sha3_pkg;

   localparam int X_AXIS         = 5;
   localparam int Y_AXIS         = 5;
   localparam int Z_AXIS         = 64;
   localparam int RATE_LANES_256 = 17;

   typedef logic [Z_AXIS-1:0]                         sha3_lane_t;
   typedef logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] sha3_state_t;

   typedef enum logic [1:0] {
      ABSORB    = 2'd0,
      HANDOFF   = 2'd1,
      WAIT_PERM = 2'd2
   } sha3_fsm_t;

   function automatic int mod5(input int v);
      return v % 5;
   endfunction

   function automatic int mod64(input int v);
      return v % 64;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_index_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lane_index_ctr : x/y lane position counters with last-lane flag     |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module lane_index_ctr #(
   parameter int X_AXIS     = sha3_pkg::X_AXIS,
   parameter int Y_AXIS     = sha3_pkg::Y_AXIS,
   parameter int RATE_LANES = sha3_pkg::RATE_LANES_256,
   parameter int XW         = $clog2(X_AXIS),
   parameter int YW         = $clog2(Y_AXIS),
   parameter int CW         = $clog2(X_AXIS*Y_AXIS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          adv,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [XW-1:0] c_X_LAST   = XW'(X_AXIS-1);
   localparam logic [CW-1:0] c_CNT_LAST = CW'(RATE_LANES-1);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == c_CNT_LAST);

   // Clear wins over advance; the last lane of a block wraps back to lane 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_y   <= '0;
         r_cnt <= '0;
      end else if (clr || (adv && w_last)) begin
         r_x   <= '0;
         r_y   <= '0;
         r_cnt <= '0;
      end else if (adv) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_x == c_X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign x    = r_x;
   assign y    = r_y;
   assign cnt  = r_cnt;
   assign last = w_last;

endmodule
`default_nettype wire

// File: rtl/perm_absorb_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | perm_absorb_loader : sponge absorb front end feeding the permutation|
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module perm_absorb_loader #(
   parameter int X_AXIS     = sha3_pkg::X_AXIS,
   parameter int Y_AXIS     = sha3_pkg::Y_AXIS,
   parameter int Z_AXIS     = sha3_pkg::Z_AXIS,
   parameter int RATE_LANES = sha3_pkg::RATE_LANES_256
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     init,
   input  logic                                     lane_valid,
   output logic                                     lane_ready,
   input  logic [Z_AXIS-1:0]                        lane_data,
   output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] state_out,
   output logic                                     state_out_valid,
   input  logic                                     state_out_ready,
   input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] perm_in,
   input  logic                                     perm_in_valid,
   output logic                                     busy
);

   import sha3_pkg::*;

   localparam int XW = $clog2(X_AXIS);
   localparam int YW = $clog2(Y_AXIS);
   localparam int CW = $clog2(X_AXIS*Y_AXIS);

   sha3_fsm_t                                 r_fsm;
   logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] r_state;
   logic                                      r_lane_ready;
   logic                                      r_state_out_valid;
   logic                                      r_busy;

   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic [CW-1:0] w_cnt;
   logic          w_last;
   logic          w_take;

   // A lane arriving alongside init is dropped, so it must not advance the index.
   assign w_take = (r_fsm == ABSORB) && lane_valid && !init;

   lane_index_ctr #(
      .X_AXIS     (X_AXIS),
      .Y_AXIS     (Y_AXIS),
      .RATE_LANES (RATE_LANES),
      .XW         (XW),
      .YW         (YW),
      .CW         (CW)
   ) u_lane_index_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (init),
      .adv   (w_take),
      .x     (w_x),
      .y     (w_y),
      .cnt   (w_cnt),
      .last  (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm             <= ABSORB;
         r_state           <= '0;
         r_lane_ready      <= 1'b1;
         r_state_out_valid <= 1'b0;
         r_busy            <= 1'b0;
      end else if (init) begin
         r_fsm             <= ABSORB;
         r_state           <= '0;
         r_lane_ready      <= 1'b1;
         r_state_out_valid <= 1'b0;
         r_busy            <= 1'b0;
      end else begin
         case (r_fsm)
            ABSORB: begin
               if (w_take) begin
                  // Only rate lanes are addressable; capacity lanes stay untouched.
                  for (int xi = 0; xi < X_AXIS; xi++) begin
                     for (int yi = 0; yi < Y_AXIS; yi++) begin
                        if (int'(w_x) == xi && int'(w_y) == yi && int'(w_cnt) < RATE_LANES)
                           r_state[xi][yi] <= r_state[xi][yi] ^ lane_data;
                     end
                  end
                  if (w_last) begin
                     r_fsm             <= HANDOFF;
                     r_lane_ready      <= 1'b0;
                     r_state_out_valid <= 1'b1;
                     r_busy            <= 1'b1;
                  end
               end
            end
            HANDOFF: begin
               if (state_out_ready) begin
                  r_fsm             <= WAIT_PERM;
                  r_state_out_valid <= 1'b0;
               end
            end
            WAIT_PERM: begin
               if (perm_in_valid) begin
                  r_state      <= perm_in;
                  r_fsm        <= ABSORB;
                  r_lane_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: begin
               r_fsm             <= ABSORB;
               r_lane_ready      <= 1'b1;
               r_state_out_valid <= 1'b0;
               r_busy            <= 1'b0;
            end
         endcase
      end
   end

   assign lane_ready      = r_lane_ready;
   assign state_out       = r_state;
   assign state_out_valid = r_state_out_valid;
   assign busy            = r_busy;

endmodule
`default_nettype wire

// File: doc/perm_absorb_loader.md
Name: perm_absorb_loader

Overview:
- Sponge absorb front end for the SHA3-256 permutation datapath.
- Accepts message lanes serially over a valid/ready stream and XORs them into the rate portion of a 5x5x64 state register.
- Hands the full state to the permutation rounds (theta first) in the [x][y][z] packed layout, then reloads the permuted state for the next block.
- It is the writer side feeding the state array that the round logic reads.

Parameters:
- X_AXIS, 5, lanes per row (x dimension)
- Y_AXIS, 5, rows (y dimension)
- Z_AXIS, 64, lane width in bits
- RATE_LANES, 17, lanes absorbed per block (1088-bit rate for SHA3-256); legal range 1..X_AXIS*Y_AXIS-1

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- init  input  1  synchronous clear of state and lane counter for a new message
- lane_valid  input  1  lane_data is valid
- lane_ready  output  1  block can accept a lane
- lane_data  input  Z_AXIS  message lane; bit z maps to state[x][y][z]
- state_out  output  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  current state register, driven directly
- state_out_valid  output  1  absorbed block ready for permutation
- state_out_ready  input  1  permutation accepts state_out
- perm_in  input  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  permuted state returned
- perm_in_valid  input  1  perm_in valid, single-cycle pulse
- busy  output  1  high in HANDOFF or WAIT_PERM

Behaviour:
- Reset (rst_n low, async):
  - state = 0, lane counter cnt = 0, FSM = ABSORB.
  - Outputs: lane_ready = 1, state_out_valid = 0, busy = 0, state_out = 0.
- Lane mapping: lane index i = cnt; x = i mod 5; y = i div 5. Lanes fill x first, then y.
- FSM states:
  - ABSORB
    - lane_ready = 1.
    - On lane_valid & lane_ready: state[x][y] <= state[x][y] ^ lane_data; cnt++.
    - When the handshake occurs with cnt == RATE_LANES-1: cnt <= 0, go to HANDOFF.
    - Latency: the XOR is visible on state_out the cycle after the handshake.
  - HANDOFF
    - state_out_valid = 1, lane_ready = 0.
    - On state_out_ready: go to WAIT_PERM.
    - state_out is held stable while valid and not ready.
  - WAIT_PERM
    - lane_ready = 0, state_out_valid = 0.
    - On perm_in_valid: state <= perm_in, go to ABSORB.
    - New lanes are accepted the cycle after the load.
- All outputs are registered or decoded directly from the state register. There is no combinational path from lane_valid to lane_ready.
- Capacity lanes (index >= RATE_LANES) are never written by lane input; only perm_in, init or reset change them.
- Boundary conditions:
  - init is honoured in any state and has priority over every other event in the same cycle: state = 0, cnt = 0, FSM = ABSORB. A lane presented in the same cycle as init is dropped (not absorbed); lane_ready remains as decoded from the current state.
  - perm_in_valid outside WAIT_PERM is ignored.
  - state_out_ready outside HANDOFF is ignored.
  - lane_valid with lane_ready low: no effect; the source holds the data.
  - If perm_in_valid and the WAIT_PERM entry occur in the same cycle (the HANDOFF cycle), perm_in is ignored; the permutation must pulse after acceptance.
  - rst_n asserted mid-block or mid-permutation: immediate return to the reset values above; the partially absorbed block is lost.
- Widths:
  - cnt is $clog2(X_AXIS*Y_AXIS) bits and saturates only via the transition above.
  - x and y are derived by combinational div/mod on cnt, or by separate x/y counters with x wrapping 4->0 and incrementing y.

Decomposition:
- Shared package (sha3_pkg):
  - X_AXIS, Y_AXIS, Z_AXIS, RATE_LANES_256 = 17 constants.
  - State array typedef sha3_state_t ([5][5][64]).
  - Lane typedef sha3_lane_t.
  - FSM enum {ABSORB, HANDOFF, WAIT_PERM}.
  - Existing mod5/mod64 helpers move here.
- One sub-module: lane_index_ctr. It holds the x/y counters, the last-lane flag and the synchronous clear. The XOR/write enables and the FSM stay in the top level.

Test Plan:
- Reset then 17 lanes of 64'h1 with lane_valid held high:
  - state[x][y] = 64'h1 for lane indices 0..16.
  - All others = 0.
  - state_out_valid rises the cycle after the 17th handshake.
  - busy = 1.
- HANDOFF with state_out_ready low for 5 cycles, then high:
  - state_out stable and lane_ready = 0 throughout.
  - WAIT_PERM entered the next cycle.
- perm_in = all 64'hA5A5A5A5A5A5A5A5 with a perm_in_valid pulse, then 17 lanes of 64'hFFFFFFFFFFFFFFFF:
  - Rate lanes = 64'h5A5A5A5A5A5A5A5A.
  - Capacity lanes (indices 17..24) remain 64'hA5A5A5A5A5A5A5A5.
- init asserted after 9 lanes, with lane_valid high in the same cycle:
  - state all 0 and cnt = 0.
  - That lane is not absorbed; the next lane lands at x=0, y=0.
- perm_in_valid pulsed during ABSORB, and state_out_ready during ABSORB: no state or FSM change.
- rst_n dropped asynchronously mid-WAIT_PERM: outputs at reset values before the next clock edge; lane_ready = 1 after release.
